// File: rtl/quad_decoder.sv
// Filtered quadrature decoder: synchronise, deglitch, decode A/B into step/dir/count/err.
// Define QUAD_X4_EN for x4 decode (every legal edge counts); default is x1 (count only on entry to 00).
`timescale 1ns/1ps
module quad_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int COUNT_W    = 8
) (
  input  logic               MHz50Clk,
  input  logic               reset,
  input  logic               A,
  input  logic               B,
  input  logic               clear,
  input  logic               err_clr,
  output logic               step,
  output logic               dir,
  output logic [COUNT_W-1:0] count,
  output logic               err
);

  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  logic [1:0] raw;
  logic [1:0] filt;
  logic [1:0] loaded;

  assign raw = {A, B};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bit
      logic       s1_q;
      logic       s2_q;
      logic       filt_q;
      logic       loaded_q;
      logic [7:0] cnt_q;

      always_ff @(posedge MHz50Clk) begin
        if (reset) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          filt_q   <= 1'b0;
          loaded_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          s1_q <= raw[gi];
          s2_q <= s1_q;
          // Before the first load the filtered bit shadows s2 and the counter measures its stability.
          if (!loaded_q) begin
            filt_q <= s2_q;
            if (s2_q != filt_q) begin
              cnt_q <= '0;
            end else if (cnt_q == FILT_LAST) begin
              loaded_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end else if (s2_q != filt_q) begin
            if (cnt_q == FILT_LAST) begin
              filt_q <= s2_q;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
      end

      assign filt[gi]   = filt_q;
      assign loaded[gi] = loaded_q;
    end
  endgenerate

  // Position along the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  logic [1:0]         prev_q;
  logic               primed_q;
  logic               step_q;
  logic               dir_q;
  logic [COUNT_W-1:0] count_q;
  logic               err_q;

  logic [1:0] delta_d;
  logic       fwd_d;
  logic       rev_d;
  logic       illegal_d;

  always_comb begin
    delta_d   = gray_pos(filt) - gray_pos(prev_q);
    illegal_d = primed_q && (delta_d == 2'd2);
`ifdef QUAD_X4_EN
    fwd_d     = primed_q && (delta_d == 2'd1);
    rev_d     = primed_q && (delta_d == 2'd3);
`else
    fwd_d     = primed_q && (delta_d == 2'd1) && (filt == 2'b00);
    rev_d     = primed_q && (delta_d == 2'd3) && (filt == 2'b00);
`endif
  end

  always_ff @(posedge MHz50Clk) begin
    if (reset) begin
      prev_q   <= 2'b00;
      primed_q <= 1'b0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= filt;
      primed_q <= &loaded;
      step_q   <= fwd_d | rev_d;
      if (fwd_d | rev_d) begin
        dir_q <= fwd_d;
      end
      if (clear) begin
        count_q <= '0;
      end else if (fwd_d) begin
        count_q <= count_q + COUNT_W'(1);
      end else if (rev_d) begin
        count_q <= count_q - COUNT_W'(1);
      end
      if (illegal_d) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign step  = step_q;
  assign dir   = dir_q;
  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (default parameters); expectations follow QUAD_X4_EN.
`timescale 1ns/1ps
module tb_quad_decoder;

`ifdef QUAD_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       a;
  logic       b;
  logic       clear;
  logic       err_clr;
  logic       step;
  logic       dir;
  logic [7:0] count;
  logic       err;

  quad_decoder #(.FILTER_LEN(4), .COUNT_W(8)) dut (
    .MHz50Clk (clk),
    .reset    (reset),
    .A        (a),
    .B        (b),
    .clear    (clear),
    .err_clr  (err_clr),
    .step     (step),
    .dir      (dir),
    .count    (count),
    .err      (err)
  );

  always #10 clk = ~clk;

  int step_cnt = 0;
  always @(negedge clk) if (step === 1'b1) step_cnt++;

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  typedef struct {
    logic       a;
    logic       b;
    int         hold;
    logic [7:0] exp_count;
    int         exp_steps;
    logic       exp_dir;
  } vec_t;

  vec_t tbl[11];

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int s0;
      s0 = step_cnt;
      a = tbl[i].a;
      b = tbl[i].b;
      hold(tbl[i].hold);
      $display("row %0d ab=%b%b count=%02h steps=%0d dir=%b err=%b",
               i, a, b, count, step_cnt - s0, dir, err);
      chk($sformatf("row%0d_count", i), count, tbl[i].exp_count);
      chk($sformatf("row%0d_steps", i), step_cnt - s0, tbl[i].exp_steps);
      chk($sformatf("row%0d_dir", i), dir, tbl[i].exp_dir);
      chk($sformatf("row%0d_err", i), err, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] fwd_seq[4];
    int         lat;
    int         s0;
    int         nmoves;

    fwd_seq = '{2'b10, 2'b11, 2'b01, 2'b00};

    // forward: 00->10->11->01 (the final ->00 is timed by hand)
    tbl[0]  = '{1'b1, 1'b0, 20, (X4 ? 8'h01 : 8'h00), (X4 ? 1 : 0), X4};
    tbl[1]  = '{1'b1, 1'b1, 20, (X4 ? 8'h02 : 8'h00), (X4 ? 1 : 0), X4};
    tbl[2]  = '{1'b0, 1'b1, 20, (X4 ? 8'h03 : 8'h00), (X4 ? 1 : 0), X4};
    // reverse from 0: 00->01->11->10->00
    tbl[3]  = '{1'b0, 1'b1, 20, (X4 ? 8'hFF : 8'h00), (X4 ? 1 : 0), !X4};
    tbl[4]  = '{1'b1, 1'b1, 20, (X4 ? 8'hFE : 8'h00), (X4 ? 1 : 0), !X4};
    tbl[5]  = '{1'b1, 1'b0, 20, (X4 ? 8'hFD : 8'h00), (X4 ? 1 : 0), !X4};
    tbl[6]  = '{1'b0, 1'b0, 20, (X4 ? 8'hFC : 8'hFF), 1, 1'b0};
    // 3-cycle glitch rejected, 4-cycle pulse accepted
    tbl[7]  = '{1'b1, 1'b0, 3,  (X4 ? 8'hFC : 8'hFF), 0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 20, (X4 ? 8'hFC : 8'hFF), 0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 4,  (X4 ? 8'hFC : 8'hFF), 0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 20, (X4 ? 8'hFC : 8'hFE), (X4 ? 2 : 1), 1'b0};

    reset = 1'b1; a = 1'b0; b = 1'b0; clear = 1'b0; err_clr = 1'b0;
    hold(3);
    chk("reset_step", step, 0);
    chk("reset_dir", dir, 0);
    chk("reset_count", count, 0);
    chk("reset_err", err, 0);
    reset = 1'b0;
    hold(10);

    run_rows(0, 2);

    // 01 -> 00 counts forward in both modes; measure its latency
    s0 = step_cnt; lat = 0; b = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (step === 1'b1) begin lat = cyc; break; end
    end
    $display("latency edge->step = %0d cycles", lat);
    chk("step_latency", lat, 7);
    hold(2);
    chk("fwd_final_count", count, X4 ? 4 : 1);
    chk("fwd_final_dir", dir, 1);
    chk("fwd_final_steps", step_cnt - s0, 1);

    clear = 1'b1; tick(); clear = 1'b0;
    $display("clear count=%02h", count);
    chk("clear_count", count, 0);

    run_rows(3, 10);

    // illegal 00 -> 11
    s0 = step_cnt; lat = 0; a = 1'b1; b = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (err === 1'b1) begin lat = cyc; break; end
    end
    hold(2);
    $display("illegal 00->11 err_latency=%0d count=%02h dir=%b", lat, count, dir);
    chk("err_latency", lat, 7);
    chk("illegal_steps", step_cnt - s0, 0);
    chk("illegal_count", count, X4 ? 8'hFC : 8'hFE);
    chk("illegal_dir", dir, 0);

    err_clr = 1'b1; tick(); err_clr = 1'b0;
    $display("err_clr alone err=%b", err);
    chk("err_clr_alone", err, 0);

    // second illegal 11 -> 00 with err_clr held through the setting edge
    s0 = step_cnt; a = 1'b0; b = 1'b0; err_clr = 1'b1;
    hold(7);
    err_clr = 1'b0;
    $display("err_clr vs illegal err=%b", err);
    chk("err_set_wins", err, 1);
    hold(10);
    chk("err_sticky", err, 1);
    chk("illegal2_steps", step_cnt - s0, 0);

    // clear in the same cycle as a forward step (01 -> 00)
    b = 1'b1; hold(20);
    b = 1'b0; hold(6);
    clear = 1'b1; tick();
    $display("clear race step=%b dir=%b count=%02h", step, dir, count);
    chk("race_step", step, 1);
    chk("race_dir", dir, 1);
    chk("race_count", count, 0);
    clear = 1'b0;
    hold(3);
    chk("race_count_after", count, 0);

    // walk forward to count=3
    nmoves = X4 ? 3 : 12;
    for (int i = 0; i < nmoves; i++) begin
      {a, b} = fwd_seq[i % 4];
      hold(20);
    end
    $display("pre-reset count=%02h", count);
    chk("prereset_count", count, 3);

    // reset mid-operation, release with A=B=1 held
    a = 1'b1; b = 1'b1; reset = 1'b1;
    hold(4);
    chk("midreset_count", count, 0);
    chk("midreset_err", err, 0);
    reset = 1'b0;
    s0 = step_cnt;
    hold(20);
    $display("primed at 11 count=%02h err=%b", count, err);
    chk("prime_count", count, 0);
    chk("prime_err", err, 0);
    chk("prime_steps", step_cnt - s0, 0);

    a = 1'b0; hold(20);
    $display("11->01 count=%02h dir=%b", count, dir);
    chk("post_prime_11_01", count, X4 ? 1 : 0);
    b = 1'b0; hold(20);
    $display("01->00 count=%02h dir=%b", count, dir);
    chk("post_prime_01_00", count, X4 ? 2 : 1);
    chk("post_prime_dir", dir, 1);
    chk("post_prime_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
